data_cache: RTL and testbench



---
 rtl/data_cache_pkg.sv | 45 ++++
 rtl/data_cache_if.sv | 33 +++
 rtl/data_cache_array.sv | 69 ++++++
 rtl/data_cache.sv | 122 ++++++++++++
 tb/tb_data_cache.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_cache_pkg.sv
// Shared widths, FSM state type and address/line field helpers for the data cache.
// Byte-addressed CPU side, block-addressed memory side.
package data_cache_pkg;

    localparam int ADDR_W      = 8;
    localparam int NUM_BLOCKS  = 8;
    localparam int BLOCK_BYTES = 4;
    localparam int BYTE_W      = 8;

    localparam int IDX_W      = $clog2(NUM_BLOCKS);
    localparam int OFF_W      = $clog2(BLOCK_BYTES);
    localparam int TAG_W      = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W     = BLOCK_BYTES * BYTE_W;
    localparam int MEM_ADDR_W = TAG_W + IDX_W;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        MEM_READ   = 2'd2
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W +: IDX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W-1:0];
    endfunction

    // Byte k of a line lives at bits [8k+7:8k].
    function automatic logic [BYTE_W-1:0] line_byte(input logic [LINE_W-1:0] line,
                                                     input logic [OFF_W-1:0]  off);
        logic [BYTE_W-1:0] b;
        b = '0;
        for (int k = 0; k < BLOCK_BYTES; k++) begin
            if (off == OFF_W'(k)) b = line[k*BYTE_W +: BYTE_W];
        end
        return b;
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU and memory-side signals of the data cache, bundled for one port connection.
// slave = the cache itself; master = the CPU/memory environment around it.
interface data_cache_if;
    import data_cache_pkg::*;

    // Handshakes: a CPU request (read/write) is accepted in the first cycle busywait is
    // low while it is held; mem_read/mem_write stay high until an edge sees mem_busywait
    // low, and that edge completes the transfer (mem_readdata valid while busy is low).
    logic                  read;
    logic                  write;
    logic [ADDR_W-1:0]     address;
    logic [BYTE_W-1:0]     writedata;
    logic [BYTE_W-1:0]     readdata;
    logic                  busywait;

    logic                  mem_read;
    logic                  mem_write;
    logic [MEM_ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0]     mem_writedata;
    logic [LINE_W-1:0]     mem_readdata;
    logic                  mem_busywait;

    modport slave (
        input  read, write, address, writedata, mem_readdata, mem_busywait,
        output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

    modport master (
        output read, write, address, writedata, mem_readdata, mem_busywait,
        input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

endinterface

// File: rtl/data_cache_array.sv
// Line storage: valid/dirty/tag/data per line, combinational read of the indexed line,
// synchronous byte write, line fill and dirty clear on that same index.
module data_cache_array
    import data_cache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic              valid_o,
    output logic              dirty_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] line_o,
    input  logic              byte_we_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [BYTE_W-1:0] byte_i,
    input  logic              fill_i,
    input  logic [TAG_W-1:0]  fill_tag_i,
    input  logic [LINE_W-1:0] fill_line_i,
    input  logic              clean_i
);

    logic [NUM_BLOCKS-1:0] valid_q, valid_d;
    logic [NUM_BLOCKS-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [TAG_W-1:0]      tag_d  [NUM_BLOCKS];
    logic [LINE_W-1:0]     data_q [NUM_BLOCKS];
    logic [LINE_W-1:0]     data_d [NUM_BLOCKS];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (clean_i) begin
            dirty_d[idx_i] = 1'b0;
        end
        if (fill_i) begin
            valid_d[idx_i] = 1'b1;
            dirty_d[idx_i] = 1'b0;
            tag_d[idx_i]   = fill_tag_i;
            data_d[idx_i]  = fill_line_i;
        end
        if (byte_we_i) begin
            dirty_d[idx_i] = 1'b1;
            for (int k = 0; k < BLOCK_BYTES; k++) begin
                if (off_i == OFF_W'(k)) data_d[idx_i][k*BYTE_W +: BYTE_W] = byte_i;
            end
        end
    end

    // Only the bookkeeping bits are reset; tag/data are meaningless while valid is clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate byte cache: hit detection plus the
// IDLE / WRITE_BACK / MEM_READ miss FSM driving whole-line memory transfers.
module data_cache
    import data_cache_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    data_cache_if.slave bus,
    output state_t      state_o
);

    state_t state_q, state_d;

    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      req_idx;
    logic [OFF_W-1:0]      req_off;
    logic                  req;
    logic                  hit;

    logic                  line_valid;
    logic                  line_dirty;
    logic [TAG_W-1:0]      line_tag;
    logic [LINE_W-1:0]     line_data;

    logic                  byte_we;
    logic                  fill;
    logic                  clean;

    logic                  busywait;
    logic [BYTE_W-1:0]     readdata;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0]     mem_wdata;

    assign req_tag = addr_tag(bus.address);
    assign req_idx = addr_idx(bus.address);
    assign req_off = addr_off(bus.address);
    assign req     = bus.read || bus.write;
    assign hit     = line_valid && (line_tag == req_tag);

    data_cache_array u_array (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (req_idx),
        .valid_o     (line_valid),
        .dirty_o     (line_dirty),
        .tag_o       (line_tag),
        .line_o      (line_data),
        .byte_we_i   (byte_we),
        .off_i       (req_off),
        .byte_i      (bus.writedata),
        .fill_i      (fill),
        .fill_tag_i  (req_tag),
        .fill_line_i (bus.mem_readdata),
        .clean_i     (clean)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busywait  = 1'b0;
        readdata  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        byte_we   = 1'b0;
        fill      = 1'b0;
        clean     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    busywait = 1'b1;
                    state_d  = (line_valid && line_dirty) ? WRITE_BACK : MEM_READ;
                end else begin
                    // Readdata shows the stored byte even when a write to it commits this edge.
                    if (bus.read && hit) readdata = line_byte(line_data, req_off);
                    byte_we = bus.write && hit;
                end
            end
            WRITE_BACK: begin
                busywait  = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {line_tag, req_idx};
                mem_wdata = line_data;
                if (!bus.mem_busywait) begin
                    clean   = 1'b1;
                    state_d = MEM_READ;
                end
            end
            MEM_READ: begin
                busywait = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = {req_tag, req_idx};
                if (!bus.mem_busywait) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busywait      = busywait;
    assign bus.readdata      = readdata;
    assign bus.mem_read      = mem_rd;
    assign bus.mem_write     = mem_wr;
    assign bus.mem_address   = mem_addr;
    assign bus.mem_writedata = mem_wdata;
    assign state_o           = state_q;

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed vector table, reset/drop corner cases,
// and random traffic against a flat byte-memory reference with a memory-transfer scoreboard.
module tb_data_cache;
    import data_cache_pkg::*;

    logic   clk;
    logic   rst;
    state_t dut_state;

    data_cache_if bus();

    data_cache dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .bus     (bus),
        .state_o (dut_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_fail = 0;

    // Memory model: busy for mem_lat cycles of an active request, then completes.
    logic [31:0] mem_blk [64];
    int          mem_lat = 0;
    int          busy_cnt = 0;

    assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && (busy_cnt < mem_lat);
    assign bus.mem_readdata = mem_blk[bus.mem_address];

    // Reference: what the CPU should see as memory, plus which block each line holds.
    logic [7:0] ref_mem [256];
    logic       m_valid [8];
    logic       m_dirty [8];
    logic [2:0] m_tag   [8];

    // Scoreboard entries: {is_writeback, block address, line data}.
    logic [38:0] exp_q[$];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        int          lat;
        logic [7:0]  exp_rd;
        int          exp_st;
        int          n_txn;
        logic [38:0] txn0;
        logic [38:0] txn1;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [38:0] txn(input logic wb, input logic [5:0] blk, input logic [31:0] d);
        return {wb, blk, d};
    endfunction

    function automatic vec_t mk(input logic rd, input logic wr, input logic [7:0] a,
                                input logic [7:0] wd, input int lat, input logic [7:0] er,
                                input int es, input int n, input logic [38:0] t0,
                                input logic [38:0] t1);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.lat = lat;
        v.exp_rd = er; v.exp_st = es; v.n_txn = n; v.txn0 = t0; v.txn1 = t1;
        return v;
    endfunction

    function automatic logic [31:0] ref_blk(input logic [5:0] b);
        return {ref_mem[{b, 2'd3}], ref_mem[{b, 2'd2}], ref_mem[{b, 2'd1}], ref_mem[{b, 2'd0}]};
    endfunction

    task automatic model_reset();
        logic [31:0] w;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 3'd0;
        end
        for (int a = 0; a < 256; a++) begin
            w = mem_blk[a / 4];
            ref_mem[a] = 8'(w >> (8 * (a % 4)));
        end
    endtask

    // Predicts read data and stall cycles for one request and records the memory traffic.
    task automatic model_req(input logic rd, input logic wr, input logic [7:0] a,
                             input logic [7:0] wd, input int lat, input bit push,
                             output logic [7:0] exp_rd, output int exp_st);
        logic [2:0] idx;
        logic [2:0] tg;
        bit         hit;
        idx = a[4:2];
        tg  = a[7:5];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        exp_st = 0;
        if (!hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                if (push) exp_q.push_back(txn(1'b1, {m_tag[idx], idx}, ref_blk({m_tag[idx], idx})));
                exp_st += lat + 1;
            end
            if (push) exp_q.push_back(txn(1'b0, {tg, idx}, ref_blk({tg, idx})));
            exp_st += lat + 2;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
        end
        exp_rd = rd ? ref_mem[a] : 8'h00;
        if (wr) begin
            ref_mem[a]   = wd;
            m_dirty[idx] = 1'b1;
        end
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [7:0] a,
                          input logic [7:0] wd, output logic [7:0] got, output int st);
        @(negedge clk);
        bus.read = rd; bus.write = wr; bus.address = a; bus.writedata = wd;
        #1;
        st = 0;
        while (bus.busywait && st < 200) begin
            st++;
            @(negedge clk);
            #1;
        end
        got = bus.readdata;
    endtask

    task automatic req_check(input string name, input logic rd, input logic wr,
                             input logic [7:0] a, input logic [7:0] wd, input int lat);
        logic [7:0] exp_rd, got;
        int         exp_st, st;
        mem_lat = lat;
        model_req(rd, wr, a, wd, lat, 1'b1, exp_rd, exp_st);
        do_req(rd, wr, a, wd, got, st);
        check({name, "_rdata"}, 64'(got), 64'(exp_rd));
        check({name, "_stalls"}, 64'(st), 64'(exp_st));
    endtask

    task automatic mem_proc();
        forever begin
            @(posedge clk);
            if (bus.mem_read || bus.mem_write) begin
                if (busy_cnt >= mem_lat) begin
                    if (bus.mem_write) mem_blk[bus.mem_address] <= bus.mem_writedata;
                    busy_cnt <= 0;
                end else begin
                    busy_cnt <= busy_cnt + 1;
                end
            end else begin
                busy_cnt <= 0;
            end
        end
    endtask

    // A transfer completes at the edge following a cycle with a request and busy low.
    task automatic mon_proc();
        logic [38:0] act;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && (bus.mem_read || bus.mem_write) && !bus.mem_busywait) begin
                act = txn(bus.mem_write, bus.mem_address,
                          bus.mem_write ? bus.mem_writedata : bus.mem_readdata);
                if (exp_q.size() == 0) check("mem_txn_unexpected", 64'(act), 64'(0));
                else check("mem_txn", 64'(act), 64'(exp_q.pop_front()));
            end
        end
    endtask

    initial begin
        logic [7:0] exp_rd, got;
        int         exp_st, st, k;

        rst = 1'b1;
        bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.writedata = '0;

        for (int i = 0; i < 64; i++) mem_blk[i] <= $urandom;
        mem_blk[6'h00] <= 32'hDDCCBBAA;
        mem_blk[6'h08] <= 32'h44332211;
        mem_blk[6'h11] <= 32'h0C0B0A09;
        mem_blk[6'h19] <= 32'h5F5E5D5C;
        mem_blk[6'h3F] <= 32'h8899EEFF;
        #1;
        model_reset();

        vecs[0]  = mk(1, 0, 8'h00, 8'h00, 5, 8'hAA, 7,  1, txn(0, 6'h00, 32'hDDCCBBAA), '0);
        vecs[1]  = mk(1, 0, 8'h03, 8'h00, 5, 8'hDD, 0,  0, '0, '0);
        vecs[2]  = mk(0, 1, 8'h01, 8'h55, 5, 8'h00, 0,  0, '0, '0);
        vecs[3]  = mk(1, 0, 8'h01, 8'h00, 5, 8'h55, 0,  0, '0, '0);
        vecs[4]  = mk(1, 0, 8'h21, 8'h00, 5, 8'h22, 13, 2, txn(1, 6'h00, 32'hDDCC55AA),
                      txn(0, 6'h08, 32'h44332211));
        vecs[5]  = mk(0, 1, 8'h44, 8'h77, 2, 8'h00, 4,  1, txn(0, 6'h11, 32'h0C0B0A09), '0);
        vecs[6]  = mk(1, 0, 8'h44, 8'h00, 2, 8'h77, 0,  0, '0, '0);
        vecs[7]  = mk(1, 0, 8'h64, 8'h00, 1, 8'h5C, 5,  2, txn(1, 6'h11, 32'h0C0B0A77),
                      txn(0, 6'h19, 32'h5F5E5D5C));
        vecs[8]  = mk(1, 0, 8'hFF, 8'h00, 0, 8'h88, 2,  1, txn(0, 6'h3F, 32'h8899EEFF), '0);
        vecs[9]  = mk(1, 1, 8'hFE, 8'h5A, 0, 8'h99, 0,  0, '0, '0);
        vecs[10] = mk(1, 0, 8'hFE, 8'h00, 0, 8'h5A, 0,  0, '0, '0);

        fork
            mem_proc();
            mon_proc();
        join_none

        repeat (3) @(negedge clk);
        #1;
        check("rst_busywait",   64'(bus.busywait),      64'(0));
        check("rst_readdata",   64'(bus.readdata),      64'(0));
        check("rst_mem_read",   64'(bus.mem_read),      64'(0));
        check("rst_mem_write",  64'(bus.mem_write),     64'(0));
        check("rst_mem_addr",   64'(bus.mem_address),   64'(0));
        check("rst_mem_wdata",  64'(bus.mem_writedata), 64'(0));
        check("rst_state",      64'(dut_state),         64'(IDLE));
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            mem_lat = vecs[i].lat;
            if (vecs[i].n_txn > 0) exp_q.push_back(vecs[i].txn0);
            if (vecs[i].n_txn > 1) exp_q.push_back(vecs[i].txn1);
            model_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].lat, 1'b0,
                      exp_rd, exp_st);
            do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, got, st);
            check($sformatf("vec%0d_rdata", i), 64'(got), 64'(vecs[i].exp_rd));
            check($sformatf("vec%0d_stalls", i), 64'(st), 64'(vecs[i].exp_st));
        end
        check("vec_txn_drain", 64'(exp_q.size()), 64'(0));

        // Reset in the middle of a fill: transfer abandoned, line stays invalid.
        mem_lat = 5;
        @(negedge clk);
        bus.read = 1'b1; bus.write = 1'b0; bus.address = 8'h03;
        repeat (3) @(negedge clk);
        #1;
        check("mr_before_rst", 64'(bus.mem_read), 64'(1));
        check("mr_addr_before_rst", 64'(bus.mem_address), 64'(6'h00));
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mr_after_rst", 64'(bus.mem_read), 64'(0));
        check("mr_addr_after_rst", 64'(bus.mem_address), 64'(0));
        check("state_after_rst", 64'(dut_state), 64'(IDLE));
        check("busy_after_rst", 64'(bus.busywait), 64'(1));
        rst = 1'b0;
        bus.read = 1'b0;
        model_reset();
        req_check("post_rst_rd03", 1'b1, 1'b0, 8'h03, 8'h00, 5);
        req_check("post_rst_rdFE", 1'b1, 1'b0, 8'hFE, 8'h00, 5);

        // Write dropped mid-miss: fill still happens, no byte written, line stays clean.
        mem_lat = 3;
        model_req(1'b0, 1'b0, 8'h80, 8'h00, 3, 1'b1, exp_rd, exp_st);
        @(negedge clk);
        bus.read = 1'b0; bus.write = 1'b1; bus.address = 8'h80; bus.writedata = 8'hAB;
        repeat (2) @(negedge clk);
        bus.write = 1'b0;
        #1;
        k = 0;
        while (bus.busywait && k < 50) begin
            k++;
            @(negedge clk);
            #1;
        end
        check("drop_completes", 64'(k < 50), 64'(1));
        req_check("drop_rd80", 1'b1, 1'b0, 8'h80, 8'h00, 3);
        req_check("drop_rdA0", 1'b1, 1'b0, 8'hA0, 8'h00, 2);

        for (int i = 0; i < 300; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            req_check($sformatf("rnd%0d", i), op != 2'd1, op == 2'd1 || op == 2'd2,
                      8'($urandom_range(0, 255)), 8'($urandom), $urandom_range(0, 3));
        end

        @(negedge clk);
        bus.read = 1'b0; bus.write = 1'b0;
        repeat (2) @(negedge clk);
        check("final_txn_drain", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
